// File: rtl/circsat_search.sv
// circsat_search: exhaustive search over a W-lane three-input circuit.
//   clk, rst      : clock, synchronous active-high reset
//   start         : launch a search; sampled only while idle
//   mode          : 0 = every lane must be satisfied, 1 = any lane suffices
//   stop_first    : 1 = stop as soon as the first solution is retired
//   busy          : a search is in progress
//   done          : one-cycle pulse when results become valid
//   found         : at least one solution was seen
//   first_sol     : lowest satisfying candidate, encoded {a,b,c}
//   sol_count     : number of satisfying candidates
module circsat_search #(
   parameter int W = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            mode,
   input  logic            stop_first,
   output logic            busy,
   output logic            done,
   output logic            found,
   output logic [3*W-1:0]  first_sol,
   output logic [3*W:0]    sol_count
);
   localparam int CW = 3 * W;
   typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_t;
   state_t          state;
   logic [CW:0]     cand;
   logic [CW:0]     cand_inc;
   logic            mode_q;
   logic            sf_q;
   logic            s1_valid;
   logic            s1_hit;
   logic [CW-1:0]   s1_cand;
   logic [W-1:0]    a, b, c, x4, x5, x6, x7, x8, x9, y;
   logic            hit;
   logic            s1_rec;
   // The gate network is kept exactly as drawn so it matches the
   // annealer-mapped circuit gate for gate.
   always_comb begin
      a        = cand[3*W-1:2*W];
      b        = cand[2*W-1:W];
      c        = cand[W-1:0];
      x4       = ~c;
      x5       = a | b;
      x6       = ~x4;
      x7       = a & b & x4;
      x8       = x5 | x6;
      x9       = x6 | x7;
      y        = x8 & x9 & x7;
      hit      = mode_q ? |y : &y;
      cand_inc = cand + (CW+1)'(1);
      s1_rec   = s1_valid & s1_hit;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cand      <= '0;
         mode_q    <= 1'b0;
         sf_q      <= 1'b0;
         s1_valid  <= 1'b0;
         s1_hit    <= 1'b0;
         s1_cand   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         found     <= 1'b0;
         first_sol <= '0;
         sol_count <= '0;
      end else begin
         // Stage 1 retires whenever it holds a valid entry.
         if (s1_rec) begin
            sol_count <= sol_count + (CW+1)'(1);
            if (!found) begin
               first_sol <= s1_cand;
               found     <= 1'b1;
            end
         end
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mode_q    <= mode;
                  sf_q      <= stop_first;
                  cand      <= '0;
                  sol_count <= '0;
                  found     <= 1'b0;
                  first_sol <= '0;
                  s1_valid  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SEARCH;
               end
            end
            SEARCH: begin
               if (sf_q && s1_rec) begin
                  // The candidate evaluated this cycle is dropped.
                  s1_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  s1_valid <= 1'b1;
                  s1_hit   <= hit;
                  s1_cand  <= cand[CW-1:0];
                  cand     <= cand_inc;
                  // Extra counter bit flags the issue of the last candidate.
                  if (cand_inc[CW]) state <= DRAIN;
               end
            end
            DRAIN: begin
               s1_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_circsat_search.sv
// tb_circsat_search: directed self-checking bench for circsat_search (W=2 and W=1).
module tb_circsat_search;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start2 = 1'b0;
   logic       start1 = 1'b0;
   logic       mode = 1'b0;
   logic       sf = 1'b0;
   logic       busy2, done2, found2;
   logic [5:0] first2;
   logic [6:0] cnt2;
   logic       busy1, done1, found1;
   logic [2:0] first1;
   logic [3:0] cnt1;
   int         checks = 0;
   int         errors = 0;

   circsat_search #(.W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(mode), .stop_first(sf),
      .busy(busy2), .done(done2), .found(found2), .first_sol(first2), .sol_count(cnt2)
   );
   circsat_search #(.W(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .mode(mode), .stop_first(sf),
      .busy(busy1), .done(done1), .found(found1), .first_sol(first1), .sol_count(cnt1)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      int seen;
      rst = 1'b1;
      repeat (3) tick;
      rst = 1'b0;
      seen = 0;
      repeat (10) begin
         tick;
         if (done2 || done1) seen++;
      end
      checks++;
      if ({busy2, done2, found2, first2, cnt2} !== 16'd0) begin
         errors++;
         $display("FAIL reset_w2 got busy=%b done=%b found=%b first=%0d cnt=%0d want all 0",
                  busy2, done2, found2, first2, cnt2);
      end
      checks++;
      if ({busy1, done1, found1, first1, cnt1} !== 10'd0) begin
         errors++;
         $display("FAIL reset_w1 got busy=%b done=%b found=%b first=%0d cnt=%0d want all 0",
                  busy1, done1, found1, first1, cnt1);
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL reset_idle_done got %0d pulses want 0", seen);
      end
   endtask

   // Launches one search on the selected instance; cycle 0 is the edge that samples start.
   // extra > 0 re-asserts start for one edge while the search is running.
   task automatic run(input bit w1, input bit m, input bit s, input int extra, input int exp_cyc,
                      input logic [5:0] exp_first, input logic [6:0] exp_cnt, input string name);
      int         cyc;
      bit         got;
      logic       bz, fd;
      logic [5:0] fs;
      logic [6:0] ct;
      mode = m;
      sf = s;
      if (w1) start1 = 1'b1; else start2 = 1'b1;
      tick;
      start1 = 1'b0;
      start2 = 1'b0;
      checks++;
      if ((w1 ? busy1 : busy2) !== 1'b1) begin
         errors++;
         $display("FAIL %s_busy_c1 got %b want 1", name, w1 ? busy1 : busy2);
      end
      got = 0;
      cyc = 0;
      for (int n = 1; n <= 200 && !got; n++) begin
         if (n == extra) begin
            if (w1) start1 = 1'b1; else start2 = 1'b1;
         end
         tick;
         start1 = 1'b0;
         start2 = 1'b0;
         if (w1 ? done1 : done2) begin
            got = 1;
            cyc = n + 1;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_timeout got no done want done at cycle %0d", name, exp_cyc);
         return;
      end
      bz = w1 ? busy1 : busy2;
      fd = w1 ? found1 : found2;
      fs = w1 ? {3'b0, first1} : first2;
      ct = w1 ? {3'b0, cnt1} : cnt2;
      checks++;
      if (cyc !== exp_cyc) begin
         errors++;
         $display("FAIL %s_done_cycle got %0d want %0d", name, cyc, exp_cyc);
      end
      checks++;
      if (bz !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy_at_done got %b want 0", name, bz);
      end
      checks++;
      if (fd !== (exp_cnt != 0)) begin
         errors++;
         $display("FAIL %s_found got %b want %b", name, fd, exp_cnt != 0);
      end
      checks++;
      if (fs !== exp_first) begin
         errors++;
         $display("FAIL %s_first_sol got %0d want %0d", name, fs, exp_first);
      end
      checks++;
      if (ct !== exp_cnt) begin
         errors++;
         $display("FAIL %s_sol_count got %0d want %0d", name, ct, exp_cnt);
      end
      // start during the DONE cycle must be ignored and results must hold.
      if (w1) start1 = 1'b1; else start2 = 1'b1;
      tick;
      start1 = 1'b0;
      start2 = 1'b0;
      tick;
      checks++;
      if ((w1 ? busy1 : busy2) !== 1'b0) begin
         errors++;
         $display("FAIL %s_start_in_done got busy=%b want 0", name, w1 ? busy1 : busy2);
      end
      checks++;
      if ((w1 ? {3'b0, cnt1} : cnt2) !== exp_cnt) begin
         errors++;
         $display("FAIL %s_hold got %0d want %0d", name, w1 ? {3'b0, cnt1} : cnt2, exp_cnt);
      end
   endtask

   task automatic test_full_and;
      run(1'b0, 1'b0, 1'b0, 0, 66, 6'd60, 7'd1, "w2_and");
   endtask

   task automatic test_full_or;
      run(1'b0, 1'b1, 1'b0, 0, 66, 6'd20, 7'd15, "w2_or");
   endtask

   task automatic test_stop_first;
      run(1'b0, 1'b1, 1'b1, 0, 23, 6'd20, 7'd1, "w2_or_stop");
   endtask

   task automatic test_w1;
      run(1'b1, 1'b0, 1'b0, 0, 10, 6'd6, 7'd1, "w1_and");
   endtask

   task automatic test_abort;
      int seen;
      mode = 1'b1;
      sf = 1'b0;
      start2 = 1'b1;
      tick;
      start2 = 1'b0;
      repeat (29) tick;
      checks++;
      if (found2 !== 1'b1 || busy2 !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre got found=%b busy=%b want 1 1", found2, busy2);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++;
      if ({busy2, done2, found2, first2, cnt2} !== 16'd0) begin
         errors++;
         $display("FAIL abort_zero got busy=%b done=%b found=%b first=%0d cnt=%0d want all 0",
                  busy2, done2, found2, first2, cnt2);
      end
      seen = 0;
      repeat (80) begin
         tick;
         if (done2 || busy2) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_quiet got %0d active cycles want 0", seen);
      end
      run(1'b0, 1'b1, 1'b0, 10, 66, 6'd20, 7'd15, "rerun_busy_start");
   endtask

   initial begin
      test_reset;
      test_full_and;
      test_full_or;
      test_stop_first;
      test_w1;
      test_abort;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/circsat_search.md
Name: circsat_search

Overview:
- Sequential, parametrised successor to the team's three-input circuit-satisfiability example.
- Evaluates a W-lane bitwise version of the same circuit: per lane i, y[i] = f(a[i], b[i], c[i]).
- An on-chip engine exhaustively enumerates every input assignment. It reports the solution count and the first satisfying assignment, and can optionally stop at the first hit.
- Used as a classical golden model and checker alongside the annealer-mapped combinational circuit.

Parameters:
- W, 2, number of lanes; a, b and c are each W bits wide. Legal range 1..8.
- CW, 3*W, candidate width (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a search. Sampled in IDLE only.
- mode  input  1  sampled with start. 0 = all lanes must satisfy (AND). 1 = any lane satisfies (OR).
- stop_first  input  1  sampled with start. 1 = terminate at the first solution.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- found  output  1  at least one solution was seen.
- first_sol  output  CW  first satisfying candidate, encoded {a,b,c}.
- sol_count  output  CW+1  number of satisfying candidates evaluated.

Behaviour:
- Circuit, per lane:
  - x4 = ~c; x5 = a|b; x6 = ~x4; x7 = a&b&x4.
  - x8 = x5|x6; x9 = x6|x7; y = x8&x9&x7.
  - Implement this gate structure literally; do not hand-simplify it.
- Candidate encoding: cand = {a, b, c}, with a = cand[3W-1:2W], b = cand[2W-1:W], c = cand[W-1:0]. Enumeration runs ascending from 0 to 2^CW-1.
- Hit condition: mode 0 gives hit = &y; mode 1 gives hit = |y.
- FSM states: IDLE, SEARCH, DRAIN, DONE.
- IDLE:
  - start=1 latches mode and stop_first, clears cand, sol_count, found and first_sol, then moves to SEARCH.
  - start=0 keeps the previous results stable.
- SEARCH: one candidate per cycle.
  - Stage 0: evaluate cand combinationally and register {hit, cand} into a stage-1 register together with a valid bit.
  - cand then increments.
  - After issuing cand = 2^CW-1, go to DRAIN. The counter is CW+1 bits, so wrap is detected without aliasing.
- Stage 1, whenever valid:
  - On hit, sol_count increments.
  - On hit with found=0, first_sol <= candidate and found <= 1.
- Early stop: stop_first=1 and stage 1 records a hit → go to DONE. The candidate issued that same cycle is discarded and not counted.
- DRAIN: one cycle that retires the last stage-1 entry, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then return to IDLE.
- Full-search latency: start sampled at cycle 0, SEARCH at cycles 1..2^CW, DRAIN at 2^CW+1, done at 2^CW+2.
- start while busy or in DONE is ignored. It is not queued.
- Reset values: busy=0, done=0, found=0, first_sol=0, sol_count=0; FSM in IDLE; stage-1 valid=0.
- rst mid-search aborts immediately. The next cycle shows the reset values and no done pulse is produced.
- No solutions: found=0, first_sol=0, sol_count=0 at done.
- Outputs are registered. sol_count never saturates, because its maximum is 2^CW, which fits in CW+1 bits.

Test Plan:
- Reset then idle: rst high 3 cycles, start=0 for 10 cycles → all outputs 0, done never pulses.
- W=2, mode=0, stop_first=0, start pulse →
  - done exactly at cycle 66.
  - found=1, first_sol=6'd60 (a=11, b=11, c=00), sol_count=1.
- W=2, mode=1, stop_first=0 → done at cycle 66; found=1, first_sol=6'd20, sol_count=15.
- W=2, mode=1, stop_first=1 →
  - done well before cycle 66, on the cycle after the stage-1 hit for cand 20.
  - first_sol=20, sol_count=1.
- W=1, mode=0 → done at cycle 10; first_sol=3'b110, sol_count=1.
- Mid-search rst at cycle 30 (W=2), then a new start →
  - Immediate return to IDLE with zeroed outputs and no done pulse.
  - The rerun gives the same results as the uninterrupted run.
  - A start asserted while busy is ignored: the done timing is unchanged.
